// File: rtl/mul_pkg.sv
// Shared types and constants for the multiply unit controller.
package mul_pkg;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011
   } funct3_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_FIN,
      S_DRAIN
   } state_e;

   localparam int MUL_LATENCY_NOMINAL = 6;

endpackage

// File: rtl/mul_sign_fix.sv
// Sign handling around an unsigned multiplier: operand magnitudes in,
// conditionally negated 64-bit product out.
module mul_sign_fix (
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        abs_a,
   input  logic        abs_b,
   input  logic [63:0] prod_in,
   input  logic        negate,
   output logic [31:0] mag_a,
   output logic [31:0] mag_b,
   output logic [63:0] prod_out
);

   // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
   assign mag_a    = (abs_a && op_a[31]) ? (~op_a + 32'd1) : op_a;
   assign mag_b    = (abs_b && op_b[31]) ? (~op_b + 32'd1) : op_b;
   assign prod_out = negate ? (~prod_in + 64'd1) : prod_in;

endmodule

// File: rtl/mul_unit_ctrl.sv
// Sequencer for an external unsigned multiplier implementing MUL/MULH/MULHSU/MULHU.
// Optional one-entry result cache enabled with `define MUL_OPCACHE_EN.
module mul_unit_ctrl #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] result,
   output logic        result_valid,
   output logic        err,
   output logic [31:0] mult_a,
   output logic [31:0] mult_b,
   output logic        mult_calc,
   input  logic [63:0] mult_product,
   input  logic        mult_done
);
   import mul_pkg::*;

   localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_e        state, state_nxt;
   funct3_e       op;
   logic          accept, hit, timeout, waiting;
   logic          abs_a, abs_b, neg_in, neg_q, hi_q;
   logic [31:0]   mag_a, mag_b;
   logic [63:0]   prod_q, prod_fix;
   logic [CW-1:0] cnt;

   assign op = funct3_e'(funct3);

   mul_sign_fix u_sign_fix (
      .op_a     (rs1),
      .op_b     (rs2),
      .abs_a    (abs_a),
      .abs_b    (abs_b),
      .prod_in  (mult_product),
      .negate   (neg_q),
      .mag_a    (mag_a),
      .mag_b    (mag_b),
      .prod_out (prod_fix)
   );

   always_comb begin
      abs_a  = (op == F3_MULH) || (op == F3_MULHSU);
      abs_b  = (op == F3_MULH);
      neg_in = 1'b0;
      case (op)
         F3_MULH:   neg_in = rs1[31] ^ rs2[31];
         F3_MULHSU: neg_in = rs1[31];
         default:   neg_in = 1'b0;
      endcase
   end

   assign accept  = (state == S_IDLE) && start && !funct3[2];
   assign waiting = (state == S_WAIT) || (state == S_DRAIN);
   assign timeout = waiting && !mult_done && (cnt == CNT_LAST);

   assign busy         = (state != S_IDLE);
   assign mult_calc    = (state == S_ISSUE);
   assign result_valid = (state == S_FIN);

`ifdef MUL_OPCACHE_EN
   logic        c_valid;
   logic [31:0] c_rs1, c_rs2;
   logic [1:0]  c_mode;

   // The low word is sign-agnostic, so a MUL can reuse any cached mode.
   assign hit = c_valid && (rs1 == c_rs1) && (rs2 == c_rs2) &&
                ((funct3[1:0] == 2'b00) || (funct3[1:0] == c_mode));

   // Tags are written on a miss and marked valid once that op completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         c_valid <= 1'b0;
         c_rs1   <= '0;
         c_rs2   <= '0;
         c_mode  <= '0;
      end else if (flush || timeout) begin
         c_valid <= 1'b0;
      end else if (accept && !hit) begin
         c_valid <= 1'b0;
         c_rs1   <= rs1;
         c_rs2   <= rs2;
         c_mode  <= funct3[1:0];
      end else if ((state == S_WAIT) && mult_done) begin
         c_valid <= 1'b1;
      end
   end
`else
   assign hit = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = hit ? S_FIN : S_ISSUE;
         S_ISSUE: state_nxt = flush ? S_DRAIN : S_WAIT;
         S_WAIT: begin
            if (mult_done)    state_nxt = flush ? S_IDLE : S_FIN;
            else if (timeout) state_nxt = S_IDLE;
            else if (flush)   state_nxt = S_DRAIN;
         end
         S_DRAIN: if (mult_done || timeout) state_nxt = S_IDLE;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         mult_a <= '0;
         mult_b <= '0;
         neg_q  <= 1'b0;
         hi_q   <= 1'b0;
         prod_q <= '0;
         result <= '0;
         err    <= 1'b0;
         cnt    <= '0;
      end else begin
         state <= state_nxt;
         err   <= timeout;
         cnt   <= waiting ? cnt + 1'b1 : '0;
         if (accept && !hit) begin
            mult_a <= mag_a;
            mult_b <= mag_b;
            neg_q  <= neg_in;
            hi_q   <= (funct3[1:0] != 2'b00);
         end
`ifdef MUL_OPCACHE_EN
         if (accept && hit) begin
            hi_q   <= (funct3[1:0] != 2'b00);
            result <= (funct3[1:0] != 2'b00) ? prod_q[63:32] : prod_q[31:0];
         end
`endif
         // A flushed op that completes in the same cycle is discarded.
         if ((state == S_WAIT) && mult_done && !flush) begin
            prod_q <= prod_fix;
            result <= hi_q ? prod_fix[63:32] : prod_fix[31:0];
         end
      end
   end

endmodule
